execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Y86-64 sequential-processor execute stage, directly upstream of the memory stage.
- Computes valE, which is the memory address for rmmovq/mrmovq/call/pushq and the stack-pointer update for push/pop/call/ret.
- Holds the architectural condition-code register (ZF, SF, OF) and evaluates cnd for jXX/cmovXX.
- Latches a sticky halt status so CC state freezes after halt.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE.
- STACK_STEP, 8, byte adjustment applied to %rsp for call/ret/push/pop.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- icode  input  4  instruction code from decode.
- ifun  input  4  function code (ALU op or condition).
- valA  input  WIDTH  operand A from register file.
- valB  input  WIDTH  operand B from register file.
- valC  input  WIDTH  immediate/displacement.
- cc_en  input  1  enable for CC/halt update; 0 inserts a bubble (no state change).
- valE  output  WIDTH  ALU result, combinational.
- cnd  output  1  condition result, combinational from current CC.
- zf, sf, of  output  1 each  registered condition codes.
- halted  output  1  registered sticky halt flag.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: applied only at a rising clk edge while reset=1.
- Reset values: zf=1, sf=0, of=0, halted=0. valE and cnd follow the combinational rules below.
- valE is combinational, zero-latency, WIDTH bits, two's-complement with wrap-around (carry discarded). It is selected by icode:
  - 2 cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB + valC.
  - 6 OPq: ifun 0 gives valB+valA; 1 gives valB-valA; 2 gives valB&valA; 3 gives valB^valA; ifun>3 gives 0.
  - 8 call, A pushq: valB - STACK_STEP.
  - 9 ret, B popq: valB + STACK_STEP.
  - 0, 1, 7, C-F: 0.
- cnd is combinational from the registered zf/sf/of, and is valid only for icode 2 or 7; it is 0 for every other icode.
  - ifun 0: 1.
  - ifun 1 le: (sf^of)|zf.
  - ifun 2 l: sf^of.
  - ifun 3 e: zf.
  - ifun 4 ne: ~zf.
  - ifun 5 ge: ~(sf^of).
  - ifun 6 g: ~(sf^of)&~zf.
  - ifun>6: 0.
- CC update happens at posedge clk when reset=0, cc_en=1, halted=0, icode=6 and ifun<=3:
  - zf = (valE==0).
  - sf = valE[WIDTH-1].
  - of for add: sign(valA)==sign(valB) and sign(valE)!=sign(valB).
  - of for sub: sign(valA)!=sign(valB) and sign(valE)!=sign(valB).
  - of for and/xor: 0.
- CC holds in all other cases, including OPq with ifun>3.
- cnd is always computed from the pre-update CC. An OPq followed by jXX sees the new flags on the next cycle only.
- halted is set to 1 at posedge when cc_en=1 and icode=0. It stays 1 until reset. While halted=1, CC is frozen; valE and cnd still compute normally.
- Simultaneous events: reset=1 overrides everything, including cc_en and a halt or OPq on the same edge. A halt and an OPq cannot coincide, since icode is exclusive.
- Reset asserted mid-stream restores zf=1/sf=0/of=0/halted=0 on that edge. Inputs presented with reset=1 have no effect on state.
- cc_en=0 leaves zf/sf/of/halted unchanged for that edge regardless of icode.

Test Plan:
- Reset then jXX: reset 1 cycle, then icode=7 ifun=3 -> cnd=1 (zf=1). ifun=4 -> cnd=0. ifun=0 -> cnd=1.
- OPq sub, equal operands: icode=6 ifun=1 valA=5 valB=5 -> valE=0; after edge zf=1, sf=0, of=0. Then icode=7 ifun=2 (l) -> cnd=0; ifun=5 (ge) -> cnd=1.
- Signed overflow on add: valA=valB=64'h7FFF_FFFF_FFFF_FFFF, ifun=0 -> valE=64'hFFFF_FFFF_FFFF_FFFE; after edge sf=1, of=1, zf=0. Then ifun=2 (l) -> cnd=0.
- Address/stack paths:
  - icode=4 valB=8 valC=4 -> valE=12.
  - icode=A valB=64 -> valE=56.
  - icode=B valB=56 -> valE=64.
  - icode=8 valB=0 -> valE=64'hFFFF_FFFF_FFFF_FFF8 (wrap).
- Bubble and halt:
  - OPq xor valA=valB=3 with cc_en=0 -> valE=0 but CC unchanged.
  - Then icode=0 with cc_en=1 -> halted=1.
  - Subsequent OPq sub valA=1 valB=0 -> valE=all ones, CC still unchanged.
  - Reset -> halted=0, zf=1.
- Reset mid-stream: OPq sets sf=1, then reset=1 together with OPq add valA=valB=0 -> after edge zf=1, sf=0, of=0, halted=0.

Source files
------------

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU/address result valE, branch/cmov condition cnd, CC register, sticky halt.
// Latency: valE and cnd are combinational (0 cycles); zf/sf/of/halted update on the rising clk edge.
// Backpressure: none; cc_en=0 acts as a bubble and leaves all state untouched for that edge.
module execute_stage #(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             cc_en,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             halted
);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic sign_a, sign_b, sign_e;
  logic cc_upd;
  logic of_next;

  // Result mux: ALU ops, address generation and stack-pointer adjust, all wrap-around.
  always_comb begin
    valE = '0;
    case (icode)
      I_CMOV:           valE = valA;
      I_IRMOV:          valE = valC;
      I_RMMOV, I_MRMOV: valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          4'h0:    valE = valB + valA;
          4'h1:    valE = valB - valA;
          4'h2:    valE = valB & valA;
          4'h3:    valE = valB ^ valA;
          default: valE = '0;
        endcase
      end
      I_CALL, I_PUSH:   valE = valB - STEP;
      I_RET, I_POP:     valE = valB + STEP;
      default:          valE = '0;
    endcase
  end

  // Condition evaluation from the current (pre-update) flags; only jXX/cmovXX consume it.
  always_comb begin
    cnd = 1'b0;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ of);
        4'h6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  // Overflow derivation for the flag update; logical ops never overflow.
  always_comb begin
    sign_a  = valA[WIDTH-1];
    sign_b  = valB[WIDTH-1];
    sign_e  = valE[WIDTH-1];
    cc_upd  = cc_en && !halted && (icode == I_OPQ) && (ifun <= 4'h3);
    of_next = 1'b0;
    case (ifun)
      4'h0:    of_next = (sign_a == sign_b) && (sign_e != sign_b);
      4'h1:    of_next = (sign_a != sign_b) && (sign_e != sign_b);
      default: of_next = 1'b0;
    endcase
  end

  // CC register and sticky halt; reset wins over every other event on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      zf     <= 1'b1;
      sf     <= 1'b0;
      of     <= 1'b0;
      halted <= 1'b0;
    end else if (cc_en) begin
      if (icode == I_HALT) begin
        halted <= 1'b1;
      end
      if (cc_upd) begin
        zf <= (valE == '0);
        sf <= sign_e;
        of <= of_next;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
// Latency: combinational outputs checked 1 time unit after inputs change; flags checked after an edge.
// Backpressure: n/a; cc_en is driven explicitly to exercise bubbles.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        cc_en;
  logic [63:0] valE;
  logic        cnd;
  logic        zf;
  logic        sf;
  logic        of;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .icode  (icode),
    .ifun   (ifun),
    .valA   (valA),
    .valB   (valB),
    .valC   (valC),
    .cc_en  (cc_en),
    .valE   (valE),
    .cnd    (cnd),
    .zf     (zf),
    .sf     (sf),
    .of     (of),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then move 1 unit past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic en);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; cc_en = en;
    #1;
  endtask

  task automatic check_cc(input string tag, input logic ez, input logic es, input logic eo,
                          input logic eh);
    check({tag, "_zf"}, {63'd0, zf}, {63'd0, ez});
    check({tag, "_sf"}, {63'd0, sf}, {63'd0, es});
    check({tag, "_of"}, {63'd0, of}, {63'd0, eo});
    check({tag, "_halted"}, {63'd0, halted}, {63'd0, eh});
  endtask

  task automatic check_cnd(input string tag, input logic [3:0] fn, input logic exp);
    drive(4'h7, fn, 64'd0, 64'd0, 64'd0, 1'b1);
    check(tag, {63'd0, cnd}, {63'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; cc_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_cc("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // Fresh-reset flags: zf=1, sf=of=0.
    check_cnd("cnd_e_after_reset", 4'h3, 1'b1);
    check_cnd("cnd_ne_after_reset", 4'h4, 1'b0);
    check_cnd("cnd_always", 4'h0, 1'b1);
    check_cnd("cnd_le_after_reset", 4'h1, 1'b1);
    check_cnd("cnd_bad_ifun", 4'h7, 1'b0);

    // Sub 5-7 = -2: negative, no overflow.
    drive(4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 1'b1);
    check("sub_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("cnd_non_branch", {63'd0, cnd}, 64'd0);
    tick();
    check_cc("sub_neg", 1'b0, 1'b1, 1'b0, 1'b0);
    check_cnd("cnd_l_neg", 4'h2, 1'b1);

    // Sub equal operands.
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
    check("sub_eq_valE", valE, 64'd0);
    tick();
    check_cc("sub_eq", 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnd("cnd_l_eq", 4'h2, 1'b0);
    check_cnd("cnd_ge_eq", 4'h5, 1'b1);
    check_cnd("cnd_g_eq", 4'h6, 1'b0);

    // Signed overflow on add.
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    check("add_ovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check_cc("add_ovf", 1'b0, 1'b1, 1'b1, 1'b0);
    check_cnd("cnd_l_ovf", 4'h2, 1'b0);
    check_cnd("cnd_le_ovf", 4'h1, 1'b0);
    check_cnd("cnd_g_ovf", 4'h6, 1'b1);
    drive(4'h2, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1);
    check("cmov_l_ovf", {63'd0, cnd}, 64'd0);

    // Address, move and stack paths (none touch CC).
    drive(4'h4, 4'h0, 64'd0, 64'd8, 64'd4, 1'b1);
    check("rmmov_addr", valE, 64'd12);
    drive(4'h5, 4'h0, 64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
    check("mrmov_addr_neg_disp", valE, 64'd84);
    drive(4'hA, 4'h0, 64'd0, 64'd64, 64'd0, 1'b1);
    check("push_sp", valE, 64'd56);
    drive(4'hB, 4'h0, 64'd0, 64'd56, 64'd0, 1'b1);
    check("pop_sp", valE, 64'd64);
    drive(4'h8, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    check("call_sp_wrap", valE, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(4'h9, 4'h0, 64'd0, 64'd16, 64'd0, 1'b1);
    check("ret_sp", valE, 64'd24);
    drive(4'h2, 4'h0, 64'hDEAD_BEEF, 64'd1, 64'd2, 1'b1);
    check("cmov_valE", valE, 64'hDEAD_BEEF);
    drive(4'h3, 4'h0, 64'd1, 64'd2, 64'h1234_5678_9ABC_DEF0, 1'b1);
    check("irmov_valE", valE, 64'h1234_5678_9ABC_DEF0);
    drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 1'b1);
    check("and_valE", valE, 64'hF000);
    drive(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1);
    check("unused_icode_valE", valE, 64'd0);
    // OPq with an invalid function: valE=0 and flags hold.
    drive(4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 1'b1);
    check("opq_bad_ifun_valE", valE, 64'd0);
    tick();
    check_cc("opq_bad_ifun", 1'b0, 1'b1, 1'b1, 1'b0);

    // Bubble: xor result 0 would set zf, but cc_en=0.
    drive(4'h6, 4'h3, 64'd3, 64'd3, 64'd0, 1'b0);
    check("xor_bubble_valE", valE, 64'd0);
    tick();
    check_cc("xor_bubble", 1'b0, 1'b1, 1'b1, 1'b0);
    // Bubble on halt must not halt.
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0);
    tick();
    check_cc("halt_bubble", 1'b0, 1'b1, 1'b1, 1'b0);

    // Halt, then CC frozen.
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    tick();
    check_cc("halt", 1'b0, 1'b1, 1'b1, 1'b1);
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b1);
    check("halted_sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check_cc("halted_frozen", 1'b0, 1'b1, 1'b1, 1'b1);
    check_cnd("halted_cnd_g", 4'h6, 1'b1);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
    tick();
    check_cc("halted_frozen2", 1'b0, 1'b1, 1'b1, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cc("reset_after_halt", 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset overriding a concurrent OPq.
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b1);
    tick();
    check_cc("pre_midreset", 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    tick();
    check_cc("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset also overrides a halt on the same edge.
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    tick();
    check_cc("reset_over_halt", 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Sub overflow: 0x8000.. - 1 = 0x7FFF.. (positive, of=1).
    drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    check("sub_ovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    check_cc("sub_ovf", 1'b0, 1'b0, 1'b1, 1'b0);
    check_cnd("cnd_l_subovf", 4'h2, 1'b1);

    // xor clears of.
    drive(4'h6, 4'h3, 64'd1, 64'd0, 64'd0, 1'b1);
    check("xor_valE", valE, 64'd1);
    tick();
    check_cc("xor_clears_of", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
